// File: rtl/uart_word_tx_fifo.sv
// Transmit buffer: queues DATA_WIDTH-bit words in a DEPTH-entry FIFO and
// serialises each one into bytes for the UART sender, MSB- or LSB-first per word.
module uart_word_tx_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  byte_order,
  input  logic                  sender_ready,
  output logic [7:0]            sender_data,
  output logic                  sender_enable,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  idle
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, GUARD} state_t;

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count_q;
  state_t                state;
  logic [DATA_WIDTH-1:0] word_q;
  logic                  order_q;
  logic [IDX_W-1:0]      byte_idx;
  logic [7:0]            sel_byte;
  logic [DATA_WIDTH:0]   head;
  logic                  push, pop, fifo_empty;

  assign in_ready   = (count_q != FULL_CNT);
  assign push       = in_valid & in_ready;
  assign fifo_empty = (count_q == '0);
  // A pop happens when idle, or when the last byte's guard cycle can chain straight into the next word.
  assign pop        = !fifo_empty && ((state == IDLE) || (state == GUARD && byte_idx == LAST_IDX));
  assign head       = mem[rd_ptr];
  assign count      = count_q;
  assign idle       = (state == IDLE) && fifo_empty;

  always_comb begin
    sel_byte = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (byte_idx == IDX_W'(i))
        sel_byte = order_q ? word_q[8*i +: 8] : word_q[DATA_WIDTH-1-8*i -: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {byte_order, in_data};
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      overflow      <= 1'b0;
      state         <= IDLE;
      sender_data   <= '0;
      sender_enable <= 1'b0;
      word_q        <= '0;
      order_q       <= 1'b0;
      byte_idx      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (in_valid && !in_ready) overflow <= 1'b1;

      sender_enable <= 1'b0;
      if (pop) begin
        word_q   <= head[DATA_WIDTH-1:0];
        order_q  <= head[DATA_WIDTH];
        byte_idx <= '0;
      end

      case (state)
        IDLE: if (pop) state <= SEND;
        SEND: begin
          if (sender_ready) begin
            sender_data   <= sel_byte;
            sender_enable <= 1'b1;
            state         <= GUARD;
          end
        end
        GUARD: begin
          if (byte_idx != LAST_IDX) begin
            byte_idx <= byte_idx + 1'b1;
            state    <= SEND;
          end else if (pop) begin
            state <= SEND;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx_fifo.sv
// Directed bench for uart_word_tx_fifo: a 32-bit/4-deep instance and an 8-bit/2-deep instance.
module tb_uart_word_tx_fifo;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  logic [31:0] a_in_data;
  logic        a_in_valid, a_in_ready, a_order, a_sready, a_en, a_ovf, a_idle;
  logic [7:0]  a_sd;
  logic [2:0]  a_count;

  logic [7:0]  b_in_data;
  logic        b_in_valid, b_in_ready, b_order, b_sready, b_en, b_ovf, b_idle;
  logic [7:0]  b_sd;
  logic [1:0]  b_count;

  int passed = 0;
  int total  = 0;

  uart_word_tx_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut_a (
    .CLK(CLK), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .byte_order(a_order), .sender_ready(a_sready),
    .sender_data(a_sd), .sender_enable(a_en), .count(a_count),
    .overflow(a_ovf), .idle(a_idle)
  );

  uart_word_tx_fifo #(.DATA_WIDTH(8), .DEPTH(2)) dut_b (
    .CLK(CLK), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .byte_order(b_order), .sender_ready(b_sready),
    .sender_data(b_sd), .sender_enable(b_en), .count(b_count),
    .overflow(b_ovf), .idle(b_idle)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Steps cycles until the selected instance strobes (bounded), then checks data and spacing.
  task automatic expect_byte(input string tag, input bit use_b, input logic [7:0] exp,
                             input int exp_gap);
    int  n;
    logic en;
    logic [7:0] d;
    n = 0;
    do begin
      tick();
      n++;
      en = use_b ? b_en : a_en;
    end while (!en && n < 30);
    d = use_b ? b_sd : a_sd;
    check({tag, " strobe"}, en, 1);
    check({tag, " data"}, d, exp);
    check({tag, " gap"}, n, exp_gap);
  endtask

  task automatic push_a(input logic [31:0] d, input logic ord);
    a_in_data  = d;
    a_order    = ord;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
  endtask

  initial begin
    int seen;
    int nbytes;
    logic [7:0] got [0:31];

    reset = 1'b1;
    a_in_data = '0; a_in_valid = 0; a_order = 0; a_sready = 1;
    b_in_data = '0; b_in_valid = 0; b_order = 0; b_sready = 1;
    tick(); tick();
    reset = 1'b0;

    check("rst sender_data", a_sd, 8'h00);
    check("rst sender_enable", a_en, 0);
    check("rst in_ready", a_in_ready, 1);
    check("rst count", a_count, 0);
    check("rst overflow", a_ovf, 0);
    check("rst idle", a_idle, 1);

    // 1: MSB-first word, strobes at t+2, t+4, t+6, t+8
    push_a(32'h11223344, 1'b0);
    check("t1 count after push", a_count, 1);
    expect_byte("t1 b0", 0, 8'h11, 2);
    expect_byte("t1 b1", 0, 8'h22, 2);
    expect_byte("t1 b2", 0, 8'h33, 2);
    expect_byte("t1 b3", 0, 8'h44, 2);
    tick();
    check("t1 idle", a_idle, 1);

    // 2: LSB-first, then two back-to-back words of mixed order
    push_a(32'h11223344, 1'b1);
    expect_byte("t2 b0", 0, 8'h44, 2);
    expect_byte("t2 b1", 0, 8'h33, 2);
    expect_byte("t2 b2", 0, 8'h22, 2);
    expect_byte("t2 b3", 0, 8'h11, 2);
    tick();
    push_a(32'hAABBCCDD, 1'b0);
    push_a(32'h01020304, 1'b1);
    expect_byte("t2 w0b0", 0, 8'hAA, 1);
    expect_byte("t2 w0b1", 0, 8'hBB, 2);
    expect_byte("t2 w0b2", 0, 8'hCC, 2);
    expect_byte("t2 w0b3", 0, 8'hDD, 2);
    expect_byte("t2 w1b0", 0, 8'h04, 2);
    expect_byte("t2 w1b1", 0, 8'h03, 2);
    expect_byte("t2 w1b2", 0, 8'h02, 2);
    expect_byte("t2 w1b3", 0, 8'h01, 2);
    tick();
    check("t2 idle", a_idle, 1);

    // 3: back-pressure after the first byte
    push_a(32'h11223344, 1'b0);
    expect_byte("t3 b0", 0, 8'h11, 2);
    a_sready = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_en) seen++;
    end
    check("t3 no strobes while stalled", seen, 0);
    check("t3 data held", a_sd, 8'h11);
    a_sready = 1'b1;
    expect_byte("t3 b1", 0, 8'h22, 1);
    expect_byte("t3 b2", 0, 8'h33, 2);
    expect_byte("t3 b3", 0, 8'h44, 2);
    tick();

    // 4: fill while stalled; sixth push overflows
    a_sready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      a_in_data  = 32'(k);
      a_order    = 1'b0;
      a_in_valid = 1'b1;
      if (k == 5) check("t4 in_ready before 6th", a_in_ready, 0);
      tick();
    end
    a_in_valid = 1'b0;
    check("t4 count full", a_count, 4);
    check("t4 in_ready", a_in_ready, 0);
    check("t4 overflow", a_ovf, 1);
    a_sready = 1'b1;
    nbytes = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (a_en) begin
        if (nbytes < 32) got[nbytes] = a_sd;
        nbytes++;
      end
    end
    check("t4 byte total", nbytes, 20);
    check("t4 word0 lsb", got[3], 8'h00);
    check("t4 word3 lsb", got[15], 8'h03);
    check("t4 word4 lsb", got[19], 8'h04);
    check("t4 word4 msb", got[16], 8'h00);
    check("t4 overflow sticky", a_ovf, 1);
    check("t4 idle", a_idle, 1);

    // 5: reset mid-word with two words queued
    push_a(32'h11223344, 1'b0);
    push_a(32'hDEADBEEF, 1'b0);
    push_a(32'hCAFEF00D, 1'b0);
    check("t5 b0 strobe", a_en, 1);
    check("t5 b0 data", a_sd, 8'h11);
    tick(); tick();
    check("t5 b1 strobe", a_en, 1);
    check("t5 b1 data", a_sd, 8'h22);
    check("t5 queued", a_count, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5 count", a_count, 0);
    check("t5 idle", a_idle, 1);
    check("t5 enable", a_en, 0);
    check("t5 overflow", a_ovf, 0);
    push_a(32'h55667788, 1'b0);
    expect_byte("t5 n0", 0, 8'h55, 2);
    expect_byte("t5 n1", 0, 8'h66, 2);
    expect_byte("t5 n2", 0, 8'h77, 2);
    expect_byte("t5 n3", 0, 8'h88, 2);

    // 6: single-byte words; order bit is irrelevant
    b_in_data = 8'h5A; b_order = 1'b0; b_in_valid = 1'b1;
    tick();
    b_in_data = 8'hA5; b_order = 1'b1;
    tick();
    b_in_valid = 1'b0;
    expect_byte("t6 w0", 1, 8'h5A, 1);
    expect_byte("t6 w1", 1, 8'hA5, 2);
    tick();
    check("t6 idle", b_idle, 1);
    check("t6 overflow", b_ovf, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
